// File: rtl/cntr8_dn.sv
// cntr8_dn: loadable down-counter with an exposed 3-bit FSM, zero detect and borrow pulse.
// Build option: define CNTR8_DN_SATURATE_EN to saturate at zero instead of wrapping.
`default_nettype none

module cntr8_dn #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic [2:0]       o_state,
  output logic             o_zero,
  output logic             o_borrow
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_LOAD   = 3'b001,
    S_DEC    = 3'b010,
    S_HOLD   = 3'b011,
    S_BORROW = 3'b100
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= RST_VAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_LOAD, S_DEC, S_HOLD, S_BORROW: begin
        if (load) begin
          state_d = S_LOAD;
          cnt_d   = d_in;
        end else if (dec) begin
          if (cnt_q != '0) begin
            state_d = S_DEC;
            cnt_d   = cnt_q - WIDTH'(1);
          end else begin
`ifdef CNTR8_DN_SATURATE_EN
            state_d = S_HOLD;
`else
            state_d = S_BORROW;
            cnt_d   = {WIDTH{1'b1}};
`endif
          end
        end else if (state_q != S_IDLE) begin
          // IDLE is only left by a command; every other state parks in HOLD.
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign d_out   = cnt_q;
  assign o_state = state_q;
  assign o_zero  = (cnt_q == '0);

`ifdef CNTR8_DN_SATURATE_EN
  assign o_borrow = 1'b0;
`else
  assign o_borrow = (state_q == S_BORROW);
`endif

endmodule

`default_nettype wire

// File: tb/tb_cntr8_dn.sv
// tb_cntr8_dn: randomized and directed checks of cntr8_dn against an arithmetic reference model.
`default_nettype none

module tb_cntr8_dn;

  logic       clk = 1'b0;
  logic       reset, load, dec;
  logic [7:0] d_in, d_out;
  logic [2:0] o_state;
  logic       o_zero, o_borrow;

  int compared   = 0;
  int mismatched = 0;
  int m_cnt;
  int m_st;

  always #5 clk = ~clk;

  cntr8_dn dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .dec      (dec),
    .d_in     (d_in),
    .d_out    (d_out),
    .o_state  (o_state),
    .o_zero   (o_zero),
    .o_borrow (o_borrow)
  );

  // Expected {state, count, zero, borrow} from the model.
  function automatic logic [12:0] exp_vec();
    return {3'(m_st), 8'(m_cnt), (m_cnt == 0), (m_st == 4)};
  endfunction

  function automatic logic [12:0] act_vec();
    return {o_state, d_out, o_zero, o_borrow};
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_st  = 0;
  endtask

  // Drive one command, let one edge happen, advance the model, return 1 time unit after the edge.
  task automatic apply(input logic l, input logic v, input logic [7:0] d);
    load = l; dec = v; d_in = d;
    @(posedge clk);
    if (l) begin
      m_st = 1; m_cnt = d;
    end else if (v) begin
      if (m_cnt != 0) begin
        m_st = 2; m_cnt = m_cnt - 1;
      end else begin
`ifdef CNTR8_DN_SATURATE_EN
        m_st = 3;
`else
        m_st = 4; m_cnt = 255;
`endif
      end
    end else if (m_st != 0) begin
      m_st = 3;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; dec = 1'b0; d_in = 8'h00;
    model_reset();
    #2;
    compared++;
    if (act_vec() !== 13'b000_00000000_1_0) begin
      mismatched++;
      $display("FAIL reset_por: got %h expected %h", act_vec(), 13'b000_00000000_1_0);
    end
    #5 reset = 1'b0;
    apply(1'b0, 1'b0, 8'h00);
    compared++;
    if (act_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL reset_idle: got %h expected %h", act_vec(), exp_vec());
    end
    apply(1'b1, 1'b0, 8'h37);
    #2 reset = 1'b1;
    model_reset();
    #1;
    compared++;
    if (act_vec() !== 13'b000_00000000_1_0) begin
      mismatched++;
      $display("FAIL reset_async_mid: got %h expected %h", act_vec(), 13'b000_00000000_1_0);
    end
    #3 reset = 1'b0;
  endtask

  task automatic test_load_count();
    apply(1'b1, 1'b0, 8'h03);
    compared++;
    if (d_out !== 8'h03 || o_state !== 3'b001 || act_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL load_03: got %h expected %h", act_vec(), exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, 8'hxx);
      compared++;
      if (d_out !== 8'(2 - i) || o_state !== 3'b010 || act_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL count_down[%0d]: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    apply(1'b0, 1'b1, 8'h00);
    compared++;
    if (act_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL wrap: got %h expected %h", act_vec(), exp_vec());
    end
    apply(1'b0, 1'b0, 8'h00);
    compared++;
    if (act_vec() !== exp_vec() || o_borrow !== 1'b0 || o_state !== 3'b011) begin
      mismatched++;
      $display("FAIL wrap_then_hold: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int exp_pulses = 0;
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 1'b0, 8'h00);
      apply(1'b0, 1'b1, 8'h00);
      if (o_borrow === 1'b1) pulses++;
      if (m_st == 4) exp_pulses++;
      compared++;
      if (act_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL b2b_wrap[%0d]: got %h expected %h", k, act_vec(), exp_vec());
      end
    end
    compared++;
    if (pulses !== exp_pulses) begin
      mismatched++;
      $display("FAIL b2b_pulse_count: got %0d expected %0d", pulses, exp_pulses);
    end
  endtask

  task automatic test_priority();
    apply(1'b1, 1'b0, 8'h10);
    apply(1'b1, 1'b1, 8'hA5);
    compared++;
    if (d_out !== 8'hA5 || o_state !== 3'b001 || act_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL priority: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_hold();
    apply(1'b1, 1'b0, 8'h5C);
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 8'($urandom));
      compared++;
      if (d_out !== 8'h5C || o_state !== 3'b011 || act_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL hold[%0d]: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_in_borrow();
    apply(1'b1, 1'b0, 8'h00);
    apply(1'b0, 1'b1, 8'h00);
    #2 reset = 1'b1;
    model_reset();
    #1;
    compared++;
    if (act_vec() !== 13'b000_00000000_1_0) begin
      mismatched++;
      $display("FAIL reset_in_borrow: got %h expected %h", act_vec(), 13'b000_00000000_1_0);
    end
    #3 reset = 1'b0;
    apply(1'b0, 1'b1, 8'h00);
    compared++;
    if (act_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL first_edge_after_reset: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic l, v;
      logic [7:0] d;
      l = ($urandom_range(0, 5) == 0);
      v = ($urandom_range(0, 2) != 0);
      // Small load values keep the counter near zero so wraps occur often.
      d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      apply(l, v, d);
      compared++;
      if (act_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL random[%0d]: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_count();
    test_wrap();
    test_back_to_back();
    test_priority();
    test_hold();
    test_reset_in_borrow();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cntr8_dn.md
Name: cntr8_dn

Overview:
8-bit loadable down-counter with an explicit 3-bit state machine. It is the decrementing counterpart of the team's up-counter.
- Same command style: load / step, with the state exposed on o_state.
- Adds zero detection and a wrap (borrow) indication.
- Used for countdown timers and transfer-length tracking alongside the up-counter.

Parameters:
WIDTH, 8, counter/data width (only 8 is required to be verified).
RST_VAL, 8'h00, counter value after reset.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
load  input  1  load request; d_in is captured into the counter.
dec  input  1  decrement request.
d_in  input  8  load value.
d_out  output  8  current counter value (registered).
o_state  output  3  current FSM state encoding.
o_zero  output  1  high when d_out == 8'h00 (combinational from the counter register).
o_borrow  output  1  high for the one cycle the FSM is in BORROW.

Behaviour:
- One clock; reset is asynchronous and active-high. Reset forces:
  - state = IDLE, counter = RST_VAL (d_out = 8'h00);
  - o_state = 3'b000, o_zero = 1, o_borrow = 0.
- Counter and state are registered. Commands are sampled at the rising edge; the effect is visible on d_out/o_state in the following cycle (1-cycle latency).
- State encoding:
  - IDLE = 3'b000
  - LOAD = 3'b001
  - DEC = 3'b010
  - HOLD = 3'b011
  - BORROW = 3'b100
  - Codes 101-111 are illegal; the next-state logic maps them to IDLE and leaves the counter unchanged.
- Command priority: load > dec > none.
- Next state and counter update, from any legal state:
  - load = 1 -> LOAD; counter <= d_in (dec ignored).
  - load = 0, dec = 1, counter != 0 -> DEC; counter <= counter - 1.
  - load = 0, dec = 1, counter == 0 -> BORROW; counter <= 8'hFF (modulo-256 wrap).
  - load = 0, dec = 0: IDLE stays IDLE; LOAD, DEC, HOLD and BORROW go to HOLD. Counter is unchanged.
- IDLE is re-entered only through reset or from an illegal state code.
- Arithmetic is unsigned, modulo 2^WIDTH. There is no carry or overflow output other than o_borrow.
- o_borrow:
  - high for exactly one cycle per wrap;
  - back-to-back wraps (load 0 then dec, repeated) give one pulse per wrap.
- Reset asserted mid-operation, including while in BORROW, clears the state immediately (asynchronous); any pending command is lost.
- Reset deassertion: the first edge after deassertion samples commands normally.
- d_in is don't-care when load = 0.

Optional Feature:
CNTR8_DN_SATURATE_EN.
- Defined: dec with counter == 0 leaves the counter at 8'h00 and goes to HOLD. BORROW becomes unreachable, and o_borrow is tied to 0.
- Undefined: wrap-to-8'hFF behaviour with a BORROW pulse, as described above.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset mid-count: assert reset asynchronously between edges while d_out = 8'h37 -> d_out = 8'h00, o_state = 3'b000, o_zero = 1 immediately, without waiting for a clock edge.
2. Load then count down: load = 1, d_in = 8'h03 for one cycle, then dec = 1 for 3 cycles -> d_out 03, 02, 01, 00; o_state 001, 010, 010, 010; o_zero rises with d_out = 00.
3. Wrap at zero: d_out = 8'h00, dec = 1 for one cycle -> d_out = 8'hFF, o_state = 3'b100, o_borrow = 1 for exactly one cycle. Idle next cycle -> o_state = 3'b011, o_borrow = 0.
4. Priority: load = 1, dec = 1, d_in = 8'hA5 with d_out = 8'h10 -> d_out = 8'hA5, o_state = 3'b001 (no decrement).
5. Hold: after a load of 8'h5C, load = dec = 0 for 4 cycles -> d_out stays 8'h5C, o_state = 3'b011 throughout.
6. With CNTR8_DN_SATURATE_EN defined: d_out = 8'h00, dec = 1 for 2 cycles -> d_out stays 8'h00, o_state = 3'b011, o_borrow never asserts.
